// File: rtl/ean13_result_validator_pkg.sv
// EAN-13 result validator shared types and code-word layout.
// Digit 0 sits in the top nibble, the check digit in the bottom one.
`ifndef EAN13_DIGIT
`define EAN13_DIGIT(w, i) w[51-4*(i) -: 4]
`endif

package ean13_result_validator_pkg;

  localparam int EAN13_DIGITS = 13;
  localparam int DIGIT_W      = 4;
  localparam int CODE_W       = EAN13_DIGITS * DIGIT_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_CHECK  = 3'b010,
    ST_DECIDE = 3'b100
  } state_e;

  function automatic logic [1:0] digit_weight(input logic [3:0] idx);
    return idx[0] ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/ean13_result_validator_if.sv
// Scanner-to-validator and validator-to-reporting signal bundle.
// The master drives the scanner side, the slave publishes results.
interface ean13_result_validator_if #(
  parameter int ERR_CNT_WIDTH = 16
);
  import ean13_result_validator_pkg::*;

  logic [CODE_W-1:0]        iDataCode;
  logic                     iNewData;
  logic                     iFrameStart;
  logic [CODE_W-1:0]        oCode;
  logic                     oValid;
  logic                     oCodeStrobe;
  logic [ERR_CNT_WIDTH-1:0] oErrorCount;

  modport master (
    output iDataCode, iNewData, iFrameStart,
    input  oCode, oValid, oCodeStrobe, oErrorCount
  );

  modport slave (
    input  iDataCode, iNewData, iFrameStart,
    output oCode, oValid, oCodeStrobe, oErrorCount
  );

endinterface

// File: rtl/ean13_checksum_serial.sv
// Digit-serial EAN-13 mod-10 checksum, one digit per enabled cycle.
// oOk/oDone are registered after the check digit (idx 12) is consumed.
module ean13_checksum_serial
  import ean13_result_validator_pkg::*;
(
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iStart,
  input  logic               iEn,
  input  logic [DIGIT_W-1:0] iDigit,
  input  logic [3:0]         iIdx,
  output logic               oOk,
  output logic               oDone
);

  logic [3:0] acc_q, acc_d;
  logic       bad_q, bad_d;
  logic       ok_q, ok_d;
  logic       done_q, done_d;
  logic [5:0] sum;
  logic [5:0] red;
  logic [3:0] want;
  logic       bad_now;

  always_comb begin
    sum = {2'b00, acc_q}
        + 6'(digit_weight(iIdx)) * {2'b00, iDigit};
    // sum <= 36 for legal digits, so three subtract steps reduce it
    if (sum >= 6'd30)      red = sum - 6'd30;
    else if (sum >= 6'd20) red = sum - 6'd20;
    else if (sum >= 6'd10) red = sum - 6'd10;
    else                   red = sum;
    want    = (acc_q == 4'd0) ? 4'd0 : 4'd10 - acc_q;
    bad_now = bad_q | (iDigit > 4'd9);
    acc_d   = acc_q;
    bad_d   = bad_q;
    ok_d    = ok_q;
    done_d  = 1'b0;
    if (iStart) begin
      acc_d = 4'd0;
      bad_d = 1'b0;
      ok_d  = 1'b0;
    end else if (iEn) begin
      bad_d = bad_now;
      if (iIdx == 4'(EAN13_DIGITS - 1)) begin
        ok_d   = !bad_now && (want == iDigit);
        done_d = 1'b1;
      end else begin
        acc_d = red[3:0];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      acc_q  <= 4'd0;
      bad_q  <= 1'b0;
      ok_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      bad_q  <= bad_d;
      ok_q   <= ok_d;
      done_q <= done_d;
    end
  end

  assign oOk   = ok_q;
  assign oDone = done_q;

endmodule

// File: rtl/ean13_result_validator.sv
// Verifies, debounces and holds EAN-13 reads from the scanner stage.
// A code is published after CONFIRM_COUNT identical valid reads.
module ean13_result_validator
  import ean13_result_validator_pkg::*;
#(
  parameter int CONFIRM_COUNT = 3,
  parameter int HOLD_FRAMES   = 30,
  parameter int ERR_CNT_WIDTH = 16
) (
  input logic                      iClk,
  input logic                      iRst,
  ean13_result_validator_if.slave  bus
);

  localparam logic [3:0] CONF_MAX = 4'(CONFIRM_COUNT);
  localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES);

  state_e                   state_q, state_d;
  logic [CODE_W-1:0]        shadow_q, shadow_d;
  logic [3:0]               idx_q, idx_d;
  logic                     prev_q;
  logic [CODE_W-1:0]        cand_q, cand_d;
  logic [3:0]               conf_q, conf_d;
  logic [7:0]               frame_q, frame_d;
  logic [CODE_W-1:0]        code_q, code_d;
  logic                     valid_q, valid_d;
  logic                     strobe_q, strobe_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

  logic       read_ev;
  logic       ck_ok;
  logic       ck_done;
  logic [3:0] conf_n;
  logic [3:0] digit;

  assign read_ev = bus.iNewData && !prev_q;
  assign digit   = `EAN13_DIGIT(shadow_q, idx_q);

  ean13_checksum_serial u_ck (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (state_q == ST_IDLE && read_ev),
    .iEn    (state_q == ST_CHECK),
    .iDigit (digit),
    .iIdx   (idx_q),
    .oOk    (ck_ok),
    .oDone  (ck_done)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    cand_d   = cand_q;
    conf_d   = conf_q;
    frame_d  = frame_q;
    code_d   = code_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    err_d    = err_q;
    conf_n   = conf_q;

    if (bus.iFrameStart) begin
      frame_d = (frame_q >= HOLD_MAX) ? HOLD_MAX : frame_q + 8'd1;
      if (frame_d == HOLD_MAX) begin
        valid_d = 1'b0;
        cand_d  = '0;
        conf_d  = 4'd0;
      end
    end

    unique case (1'b1)
      state_q[0]: begin
        if (read_ev) begin
          shadow_d = bus.iDataCode;
          idx_d    = 4'd0;
          state_d  = ST_CHECK;
        end
      end
      state_q[1]: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(EAN13_DIGITS - 1)) state_d = ST_DECIDE;
      end
      state_q[2]: begin
        state_d = ST_IDLE;
        if (ck_done && ck_ok) begin
          // a valid read overrides a coinciding timeout
          frame_d = 8'd0;
          valid_d = valid_q;
          if (shadow_q == cand_q)
            conf_n = (conf_q >= CONF_MAX) ? CONF_MAX : conf_q + 4'd1;
          else
            conf_n = 4'd1;
          cand_d = shadow_q;
          conf_d = conf_n;
          if (conf_n == CONF_MAX && (!valid_q || code_q != shadow_q)) begin
            code_d   = shadow_q;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
          end
        end else begin
          err_d = (&err_q) ? err_q : err_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      idx_q    <= 4'd0;
      prev_q   <= 1'b1;
      cand_q   <= '0;
      conf_q   <= 4'd0;
      frame_q  <= 8'd0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      prev_q   <= bus.iNewData;
      cand_q   <= cand_d;
      conf_q   <= conf_d;
      frame_q  <= frame_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign bus.oCode       = code_q;
  assign bus.oValid      = valid_q;
  assign bus.oCodeStrobe = strobe_q;
  assign bus.oErrorCount = err_q;

endmodule

// File: tb/tb_ean13_result_validator.sv
// Directed bench for the EAN-13 result validator.
// Expected values are hand-computed EAN-13 checksums and latencies.
module tb_ean13_result_validator;

  localparam logic [51:0] CODE_A   = 52'h5901234123457;
  localparam logic [51:0] A_BADCK  = 52'h5901234123458;
  localparam logic [51:0] A_BADNIB = 52'h590123412345A;
  localparam logic [51:0] CODE_B   = 52'h4006381333931;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   strobes = 0;
  int   lat = 0;

  always #5 clk = ~clk;

  ean13_result_validator_if #(.ERR_CNT_WIDTH(16)) bus ();

  ean13_result_validator #(
    .CONFIRM_COUNT (3),
    .HOLD_FRAMES   (4),
    .ERR_CNT_WIDTH (16)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always @(negedge clk) if (bus.oCodeStrobe === 1'b1) strobes++;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One read: rising iNewData at edge T, then watch 16 cycles for the strobe
  task automatic rd(input logic [51:0] code, input bit retrig, input bit fs_at);
    @(negedge clk);
    bus.iDataCode = code;
    bus.iNewData  = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (bus.oCodeStrobe === 1'b1 && lat == 0) lat = c;
      if (c == 2) bus.iNewData = 1'b0;
      if (retrig && c == 5) begin
        bus.iDataCode = A_BADCK;
        bus.iNewData  = 1'b1;
      end
      if (retrig && c == 7) bus.iNewData = 1'b0;
      if (fs_at && c == 13) bus.iFrameStart = 1'b1;
      if (fs_at && c == 14) bus.iFrameStart = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    @(negedge clk);
    bus.iFrameStart = 1'b1;
    @(negedge clk);
    bus.iFrameStart = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.iDataCode   = '0;
    bus.iNewData    = 1'b0;
    bus.iFrameStart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_code", bus.oCode, 0);
    check("rst_valid", bus.oValid, 0);
    check("rst_strobe", bus.oCodeStrobe, 0);
    check("rst_err", bus.oErrorCount, 0);
    @(negedge clk) rst = 1'b0;

    repeat (3) rd(A_BADCK, 1'b0, 1'b0);
    check("badck_err", bus.oErrorCount, 3);
    check("badck_valid", bus.oValid, 0);
    check("badck_strobes", strobes, 0);
    repeat (3) rd(A_BADNIB, 1'b0, 1'b0);
    check("badnib_err", bus.oErrorCount, 6);
    check("badnib_strobes", strobes, 0);

    rd(CODE_A, 1'b0, 1'b0);
    check("a1_lat", lat, 0);
    check("a1_valid", bus.oValid, 0);
    rd(CODE_A, 1'b0, 1'b0);
    check("a2_lat", lat, 0);
    rd(CODE_A, 1'b0, 1'b0);
    check("a3_lat", lat, 14);
    check("a3_code", bus.oCode, CODE_A);
    check("a3_valid", bus.oValid, 1);
    check("a3_strobes", strobes, 1);

    repeat (2) rd(CODE_A, 1'b0, 1'b0);
    check("a_repeat_strobes", strobes, 1);
    rd(CODE_B, 1'b0, 1'b0);
    check("b1_lat", lat, 0);
    check("b1_code", bus.oCode, CODE_A);
    rd(CODE_B, 1'b0, 1'b0);
    check("b2_lat", lat, 0);
    rd(CODE_B, 1'b0, 1'b0);
    check("b3_lat", lat, 14);
    check("b3_code", bus.oCode, CODE_B);
    check("b3_strobes", strobes, 2);

    rd(CODE_B, 1'b1, 1'b0);
    check("retrig_err", bus.oErrorCount, 6);
    repeat (20) rd(CODE_B, 1'b0, 1'b0);
    check("b20_strobes", strobes, 2);
    check("b20_err", bus.oErrorCount, 6);

    repeat (3) frame();
    check("hold3_valid", bus.oValid, 1);
    frame();
    check("hold4_valid", bus.oValid, 0);
    check("hold4_code", bus.oCode, CODE_B);

    repeat (3) rd(CODE_B, 1'b0, 1'b0);
    check("repub_lat", lat, 14);
    check("repub_valid", bus.oValid, 1);
    check("repub_strobes", strobes, 3);
    repeat (3) frame();
    rd(CODE_B, 1'b0, 1'b1);
    check("coinc_valid", bus.oValid, 1);
    frame();
    check("coinc_after_valid", bus.oValid, 1);
    check("coinc_strobes", strobes, 3);

    @(negedge clk);
    bus.iDataCode = CODE_A;
    bus.iNewData  = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_code", bus.oCode, 0);
    check("mid_rst_valid", bus.oValid, 0);
    check("mid_rst_strobe", bus.oCodeStrobe, 0);
    check("mid_rst_err", bus.oErrorCount, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.iDataCode = A_BADCK;
    repeat (20) @(posedge clk);
    #1;
    check("held_level_err", bus.oErrorCount, 0);
    check("held_level_strobes", strobes, 3);
    @(negedge clk) bus.iNewData = 1'b0;
    rd(A_BADCK, 1'b0, 1'b0);
    check("post_rst_err", bus.oErrorCount, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
